// File: rtl/rhythm_key_pkg.sv
// Shared types for the keyboard event path: key constants, lane codes,
// the event record stored in the FIFO, and the press/hold tracker states.
package rhythm_key_pkg;

   localparam logic [7:0] KEY_NONE  = 8'h00;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_F     = 8'h09;
   localparam logic [7:0] KEY_J     = 8'h0D;
   localparam logic [7:0] KEY_K     = 8'h0E;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   // Width of the hold field inside the stored event record. The top-level
   // HOLD_W parameter must match this so the FIFO record carries the full count.
   localparam int EVT_HOLD_W = 12;

   typedef enum logic [2:0] {
      LANE0      = 3'd0,
      LANE1      = 3'd1,
      LANE2      = 3'd2,
      LANE3      = 3'd3,
      LANE_START = 3'd4,
      LANE_NONE  = 3'd7
   } lane_e;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } tx_state_e;

   typedef struct packed {
      logic [7:0]            code;
      logic                  press;
      lane_e                 lane;
      logic [EVT_HOLD_W-1:0] hold;
   } key_evt_t;

   // Gameplay lanes D/F/J/K, the start key, everything else is unmapped.
   function automatic lane_e lane_of(input logic [7:0] code);
      case (code)
         KEY_D:     return LANE0;
         KEY_F:     return LANE1;
         KEY_J:     return LANE2;
         KEY_K:     return LANE3;
         KEY_SPACE: return LANE_START;
         default:   return LANE_NONE;
      endcase
   endfunction

endpackage

// File: rtl/keycode_event_tx_if.sv
// Event stream between the keycode event transmitter and its consumer.
// Handshake: the master holds evt_valid and every evt_* field stable until
// the cycle in which evt_valid && evt_ready are both high at the clock edge;
// that edge transfers exactly one event. evt_ready may change freely and
// never depends combinationally on evt_valid inside the master.
interface keycode_event_tx_if
   import rhythm_key_pkg::*;
   #(parameter int HOLD_W = EVT_HOLD_W);

   logic              evt_valid;
   logic              evt_ready;
   logic [7:0]        evt_code;
   logic              evt_press;
   logic [2:0]        evt_lane;
   logic [HOLD_W-1:0] evt_hold;

   modport master (
      output evt_valid, evt_code, evt_press, evt_lane, evt_hold,
      input  evt_ready
   );

   modport slave (
      input  evt_valid, evt_code, evt_press, evt_lane, evt_hold,
      output evt_ready
   );

endinterface

// File: rtl/key_evt_fifo.sv
// Event FIFO with two ordered write ports and one read port. Slot 0 is
// written before slot 1, so a release/press pair lands in order. The caller
// only enables as many writes as 'free' allows; free already credits a pop
// happening in the same cycle.
module key_evt_fifo
   import rhythm_key_pkg::*;
   #(
      parameter  int DEPTH = 4,
      localparam int PTR_W = $clog2(DEPTH),
      localparam int CNT_W = $clog2(DEPTH + 1)
   ) (
      input  logic             frame_clk,
      input  logic             Reset,
      input  logic             wr0_en,
      input  key_evt_t         wr0_data,
      input  logic             wr1_en,
      input  key_evt_t         wr1_data,
      input  logic             rd_en,
      output key_evt_t         head,
      output logic [CNT_W-1:0] count,
      output logic [CNT_W-1:0] free
   );

   key_evt_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr_p1;
   logic [PTR_W-1:0] rd_ptr;
   logic [1:0]       n_wr;

   assign wr_ptr_p1 = wr_ptr + 1'b1;
   assign n_wr      = {1'b0, wr0_en} + {1'b0, wr1_en};

   // Head is shown only while an entry exists, so an empty FIFO presents zeros.
   assign head = (count != '0) ? mem[rd_ptr] : '0;

   // Free slots this cycle, counting the entry being popped.
   always_comb begin
      free = CNT_W'(DEPTH) - count + CNT_W'(rd_en);
   end

   // Storage, pointers (wrap modulo DEPTH) and occupancy.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr0_en) mem[wr_ptr]    <= wr0_data;
         if (wr1_en) mem[wr_ptr_p1] <= wr1_data;
         wr_ptr <= wr_ptr + PTR_W'(n_wr);
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(n_wr) - CNT_W'(rd_en);
      end
   end

endmodule

// File: rtl/keycode_event_tx.sv
// Turns the per-frame held keycode into press/release events on a
// valid/ready stream. Release events carry the hold length in frames.
// Build option FILTER_UNMAPPED_EN: when defined, events for keys outside
// the lane map (lane 7) are not pushed; the key is still tracked.
module keycode_event_tx
   import rhythm_key_pkg::*;
   #(
      parameter int DEPTH  = 4,
      parameter int HOLD_W = EVT_HOLD_W
   ) (
      input  logic          frame_clk,
      input  logic          Reset,
      input  logic [7:0]    keycode,
      keycode_event_tx_if.master evt,
      output logic          ovf,
      input  logic          ovf_clr,
      output tx_state_e     dbg_state
   );

   localparam int CNT_W = $clog2(DEPTH + 1);

   tx_state_e         state;
   tx_state_e         state_nxt;
   logic [7:0]        prev_code;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_nxt;
   logic              rel_req;
   logic              prs_req;
   logic              rel_keep;
   logic              prs_keep;
   key_evt_t          rel_evt;
   key_evt_t          prs_evt;
   key_evt_t          slot0;
   key_evt_t          slot1;
   logic              en0;
   logic              en1;
   logic              wr0_en;
   logic              wr1_en;
   logic              drop;
   logic              pop;
   key_evt_t          head;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  free;

   assign dbg_state = state;

   // State register.
   always_ff @(posedge frame_clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state: any nonzero key means a key is held.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (keycode != KEY_NONE) state_nxt = HELD;
         HELD:    if (keycode == KEY_NONE) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: which events to raise this frame and the next hold count.
   always_comb begin
      rel_req  = 1'b0;
      prs_req  = 1'b0;
      hold_nxt = hold_cnt;
      case (state)
         IDLE: begin
            if (keycode != KEY_NONE) begin
               prs_req  = 1'b1;
               hold_nxt = HOLD_W'(1);
            end
         end
         HELD: begin
            if (keycode == prev_code) begin
               if (hold_cnt != '1) hold_nxt = hold_cnt + 1'b1;
            end else if (keycode == KEY_NONE) begin
               rel_req  = 1'b1;
               hold_nxt = '0;
            end else begin
               rel_req  = 1'b1;
               prs_req  = 1'b1;
               hold_nxt = HOLD_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Previous-frame key and hold counter.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         prev_code <= KEY_NONE;
         hold_cnt  <= '0;
      end else begin
         prev_code <= keycode;
         hold_cnt  <= hold_nxt;
      end
   end

   // Build the candidate events, filter them, and pack the survivors so the
   // release (if any) always goes into write slot 0 ahead of the press.
   always_comb begin
      rel_evt = '{code: prev_code, press: 1'b0, lane: lane_of(prev_code), hold: hold_cnt};
      prs_evt = '{code: keycode,   press: 1'b1, lane: lane_of(keycode),   hold: '0};
`ifdef FILTER_UNMAPPED_EN
      rel_keep = rel_req && (rel_evt.lane != LANE_NONE);
      prs_keep = prs_req && (prs_evt.lane != LANE_NONE);
`else
      rel_keep = rel_req;
      prs_keep = prs_req;
`endif
      if (rel_keep) begin
         slot0 = rel_evt;
         slot1 = prs_evt;
         en0   = 1'b1;
         en1   = prs_keep;
      end else begin
         slot0 = prs_evt;
         slot1 = prs_evt;
         en0   = prs_keep;
         en1   = 1'b0;
      end
   end

   // Admission: take events in order while space remains, drop the rest.
   always_comb begin
      wr0_en = en0 && (free != '0);
      wr1_en = en1 && (free >= CNT_W'(2));
      drop   = (en0 && !wr0_en) || (en1 && !wr1_en);
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge frame_clk) begin
      if (Reset)        ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

   assign pop = evt.evt_valid && evt.evt_ready;

   key_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .wr0_en    (wr0_en),
      .wr0_data  (slot0),
      .wr1_en    (wr1_en),
      .wr1_data  (slot1),
      .rd_en     (pop),
      .head      (head),
      .count     (count),
      .free      (free)
   );

   assign evt.evt_valid = (count != '0);
   assign evt.evt_code  = head.code;
   assign evt.evt_press = head.press;
   assign evt.evt_lane  = head.lane;
   assign evt.evt_hold  = head.hold;

endmodule

// File: tb/tb_keycode_event_tx.sv
// Bench for keycode_event_tx: directed keycode sequences, a key-change model
// with an expected-event queue checked every cycle, and literal expectations.
module tb_keycode_event_tx;
   import rhythm_key_pkg::*;

   localparam int DEPTH  = 4;
   localparam int HOLD_W = 12;
   localparam int W      = 8 + 1 + 3 + HOLD_W;

   // ---------------- clock / reset ----------------
   logic      frame_clk = 1'b0;
   logic      Reset     = 1'b1;
   logic [7:0] keycode  = 8'h00;
   logic      ovf;
   logic      ovf_clr   = 1'b0;
   tx_state_e dbg_state;

   always #5 frame_clk = ~frame_clk;

   keycode_event_tx_if #(.HOLD_W(HOLD_W)) evt_if ();

   keycode_event_tx #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .keycode   (keycode),
      .evt       (evt_if),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int         checks = 0;
   int         errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   logic [W-1:0] m_ev[$];
   logic       m_ovf  = 1'b0;
   logic [7:0] m_prev = 8'h00;
   int         m_held = 0;
   bit         cmp_on = 1'b0;

   function automatic logic [2:0] m_lane(input logic [7:0] c);
      case (c)
         8'h07:   return 3'd0;
         8'h09:   return 3'd1;
         8'h0D:   return 3'd2;
         8'h0E:   return 3'd3;
         8'h2C:   return 3'd4;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [W-1:0] mk(input logic [7:0] c, input logic p, input int h);
      return {c, p, m_lane(c), HOLD_W'(h)};
   endfunction

   task automatic m_add(input logic [7:0] c, input logic p, input int h);
`ifdef FILTER_UNMAPPED_EN
      if (m_lane(c) == 3'd7) return;
`endif
      m_ev.push_back(mk(c, p, h));
   endtask

   // Model of one clock edge, using the inputs that are held across it.
   task automatic model_edge();
      int  free;
      bit  pop;
      bit  drop;
      if (Reset) begin
         exp_q.delete();
         m_prev = 8'h00;
         m_held = 0;
         m_ovf  = 1'b0;
      end else begin
         m_ev.delete();
         if (keycode != m_prev) begin
            if (m_prev != 8'h00) m_add(m_prev, 1'b0, m_held);
            if (keycode != 8'h00) m_add(keycode, 1'b1, 0);
         end
         pop  = (exp_q.size() != 0) && evt_if.evt_ready;
         free = DEPTH - exp_q.size() + (pop ? 1 : 0);
         if (pop) void'(exp_q.pop_front());
         drop = 1'b0;
         foreach (m_ev[i]) begin
            if (free > 0) begin
               exp_q.push_back(m_ev[i]);
               free--;
            end else begin
               drop = 1'b1;
            end
         end
         if (drop)         m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
         if (keycode == 8'h00)        m_held = 0;
         else if (keycode != m_prev)  m_held = 1;
         else if (m_held < 4095)      m_held++;
         m_prev = keycode;
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic [7:0] kc, input logic rdy, input logic clr);
      keycode          = kc;
      evt_if.evt_ready = rdy;
      ovf_clr          = clr;
      @(posedge frame_clk);
      model_edge();
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic chk_evt(input string name, input int idx, input logic [W-1:0] want);
      checks++;
      if (idx >= got_q.size()) begin
         errors++;
         $display("FAIL %s got none want %h", name, want);
      end else if (got_q[idx] !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got_q[idx], want);
      end
   endtask

   // ---------------- per-cycle compare and transfer log ----------------
   always @(negedge frame_clk) begin
      if (cmp_on) begin
         checks++;
         if (evt_if.evt_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL valid t=%0t got %b want %b", $time, evt_if.evt_valid, exp_q.size() != 0);
         end
         if (exp_q.size() != 0) begin
            checks++;
            if ({evt_if.evt_code, evt_if.evt_press, evt_if.evt_lane, evt_if.evt_hold} !== exp_q[0]) begin
               errors++;
               $display("FAIL head t=%0t got %h want %h", $time,
                        {evt_if.evt_code, evt_if.evt_press, evt_if.evt_lane, evt_if.evt_hold}, exp_q[0]);
            end
         end
         checks++;
         if (ovf !== m_ovf) begin
            errors++;
            $display("FAIL ovf t=%0t got %b want %b", $time, ovf, m_ovf);
         end
         if (evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1)
            got_q.push_back({evt_if.evt_code, evt_if.evt_press, evt_if.evt_lane, evt_if.evt_hold});
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      evt_if.evt_ready = 1'b1;
      Reset = 1'b1;
      drive(8'h00, 1'b1, 1'b0);
      cmp_on = 1'b1;
      drive(8'h00, 1'b1, 1'b0);
      chk("reset_valid", {31'b0, evt_if.evt_valid}, 32'd0);
      chk("reset_ovf",   {31'b0, ovf}, 32'd0);
      chk("reset_code",  {24'b0, evt_if.evt_code}, 32'd0);
      chk("reset_hold",  {20'b0, evt_if.evt_hold}, 32'd0);
      Reset = 1'b0;

      // 1: space tapped for one frame
      got_q.delete();
      drive(8'h2C, 1'b1, 1'b0);
      chk("t1_latency_valid", {31'b0, evt_if.evt_valid}, 32'd1);
      chk("t1_latency_code",  {24'b0, evt_if.evt_code}, 32'h2C);
      for (int i = 0; i < 3; i++) drive(8'h00, 1'b1, 1'b0);
      chk("t1_count", got_q.size(), 32'd2);
      chk_evt("t1_press",   0, {8'h2C, 1'b1, 3'd4, 12'd0});
      chk_evt("t1_release", 1, {8'h2C, 1'b0, 3'd4, 12'd1});

      // 2: D held for five frames
      got_q.delete();
      for (int i = 0; i < 5; i++) drive(8'h07, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(8'h00, 1'b1, 1'b0);
      chk("t2_count", got_q.size(), 32'd2);
      chk_evt("t2_press",   0, {8'h07, 1'b1, 3'd0, 12'd0});
      chk_evt("t2_release", 1, {8'h07, 1'b0, 3'd0, 12'd5});

      // 3: D held three frames, then straight to J
      got_q.delete();
      for (int i = 0; i < 3; i++) drive(8'h07, 1'b1, 1'b0);
      drive(8'h0D, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(8'h00, 1'b1, 1'b0);
      chk("t3_count", got_q.size(), 32'd4);
      chk_evt("t3_press_d",   0, {8'h07, 1'b1, 3'd0, 12'd0});
      chk_evt("t3_release_d", 1, {8'h07, 1'b0, 3'd0, 12'd3});
      chk_evt("t3_press_j",   2, {8'h0D, 1'b1, 3'd2, 12'd0});
      chk_evt("t3_release_j", 3, {8'h0D, 1'b0, 3'd2, 12'd1});

      // 4: consumer stalled, six events into four slots
      got_q.delete();
      for (int i = 0; i < 6; i++) drive((i % 2 == 0) ? 8'h07 : 8'h00, 1'b0, 1'b0);
      chk("t4_ovf_set",   {31'b0, ovf}, 32'd1);
      chk("t4_full_valid", {31'b0, evt_if.evt_valid}, 32'd1);
      drive(8'h07, 1'b0, 1'b1);
      chk("t4_set_wins",  {31'b0, ovf}, 32'd1);
      drive(8'h07, 1'b0, 1'b1);
      chk("t4_ovf_clr",   {31'b0, ovf}, 32'd0);
      for (int i = 0; i < 5; i++) drive(8'h07, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(8'h00, 1'b1, 1'b0);
      chk("t4_count", got_q.size(), 32'd5);
      chk_evt("t4_ev0", 0, {8'h07, 1'b1, 3'd0, 12'd0});
      chk_evt("t4_ev1", 1, {8'h07, 1'b0, 3'd0, 12'd1});
      chk_evt("t4_ev2", 2, {8'h07, 1'b1, 3'd0, 12'd0});
      chk_evt("t4_ev3", 3, {8'h07, 1'b0, 3'd0, 12'd1});
      chk_evt("t4_late_release", 4, {8'h07, 1'b0, 3'd0, 12'd7});

      // 5: reset while F is held
      got_q.delete();
      drive(8'h09, 1'b1, 1'b0);
      drive(8'h09, 1'b1, 1'b0);
      Reset = 1'b1;
      drive(8'h09, 1'b1, 1'b0);
      drive(8'h09, 1'b1, 1'b0);
      chk("t5_reset_empty", {31'b0, evt_if.evt_valid}, 32'd0);
      Reset = 1'b0;
      drive(8'h09, 1'b0, 1'b0);
      chk("t5_valid", {31'b0, evt_if.evt_valid}, 32'd1);
      chk("t5_code",  {24'b0, evt_if.evt_code}, 32'h09);
      chk("t5_press", {31'b0, evt_if.evt_press}, 32'd1);
      chk("t5_lane",  {29'b0, evt_if.evt_lane}, 32'd1);
      drive(8'h09, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(8'h00, 1'b1, 1'b0);
      chk("t5_count", got_q.size(), 32'd3);
      chk_evt("t5_pre_press",  0, {8'h09, 1'b1, 3'd1, 12'd0});
      chk_evt("t5_post_press", 1, {8'h09, 1'b1, 3'd1, 12'd0});
      chk_evt("t5_release",    2, {8'h09, 1'b0, 3'd1, 12'd2});

      // 6: unmapped key
      got_q.delete();
      drive(8'h04, 1'b1, 1'b0);
      drive(8'h04, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(8'h00, 1'b1, 1'b0);
`ifdef FILTER_UNMAPPED_EN
      chk("t6_count", got_q.size(), 32'd0);
`else
      chk("t6_count", got_q.size(), 32'd2);
      chk_evt("t6_press",   0, {8'h04, 1'b1, 3'd7, 12'd0});
      chk_evt("t6_release", 1, {8'h04, 1'b0, 3'd7, 12'd2});
`endif

      cmp_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
